// File: rtl/analog_pkg.sv
// Shared constants and types for the slow-DAC PWM scheduler.
// No logic here; clamp helper is purely combinational.
package analog_pkg;

    localparam int              PWM_NCH   = 4;
    localparam int              PWM_DW    = 24;
    localparam logic [7:0]      PWM_FULL  = 8'd156;
    localparam logic [PWM_DW-1:0] PWM_CLAMP = 24'h9C0000;

    typedef logic [1:0] ch_t;

    typedef struct packed {
        ch_t               ch;
        logic [PWM_DW-1:0] dat;
    } req_t;

    // Integer duty above full scale saturates and drops the dither bits.
    function automatic logic [PWM_DW-1:0] pwm_clamp(input logic [PWM_DW-1:0] v);
        return (v[PWM_DW-1 -: 8] > PWM_FULL) ? PWM_CLAMP : v;
    endfunction

endpackage

// File: rtl/analog_pwm_rr_arb.sv
// Two-requester round-robin arbiter; grant is combinational from req and pointer.
// Latency 0; pointer moves only on a granted transfer, grants forced low in reset.
module analog_pwm_rr_arb (
    input  logic       adc_clk_i,
    input  logic       adc_rst_i,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // prio_b=1 means requester B wins the next contested cycle.
    logic prio_b;

    always_comb begin
        gnt = 2'b00;
        if (adc_rst_i) begin
            if (req[0] && (!req[1] || !prio_b)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rst_i) begin
        if (!adc_rst_i) begin
            prio_b <= 1'b0;
        end else if (gnt[0]) begin
            prio_b <= 1'b1;
        end else if (gnt[1]) begin
            prio_b <= 1'b0;
        end
    end

endmodule

// File: rtl/analog_pwm_sched.sv
// Shadow/commit scheduler for slow-DAC PWM values from two arbitrated requesters.
// Shadow write on transfer edge, outputs update the cycle after a rising pwm_sync; rdy is combinational.
module analog_pwm_sched
    import analog_pkg::*;
#(
    parameter int NCH = PWM_NCH,
    parameter int DW  = PWM_DW
) (
    input  logic           adc_clk_i,
    input  logic           adc_rst_i,
    input  logic           cpu_vld_i,
    output logic           cpu_rdy_o,
    input  logic [1:0]     cpu_ch_i,
    input  logic [DW-1:0]  cpu_dat_i,
    input  logic           aux_vld_i,
    output logic           aux_rdy_o,
    input  logic [1:0]     aux_ch_i,
    input  logic [DW-1:0]  aux_dat_i,
    input  logic [NCH-1:0] own_i,
    input  logic           pwm_sync_i,
    output logic [DW-1:0]  dac_pwm_a_o,
    output logic [DW-1:0]  dac_pwm_b_o,
    output logic [DW-1:0]  dac_pwm_c_o,
    output logic [DW-1:0]  dac_pwm_d_o,
    output logic [NCH-1:0] pending_o,
    output logic           cpu_err_o,
    output logic           aux_err_o,
    output logic [15:0]    commit_cnt_o
);

    logic [1:0]     gnt;
    req_t           req;
    logic           owned;
    logic           wr_en;
    logic           commit;
    logic           sync_q;
    logic [DW-1:0]  shadow [NCH];
    logic [DW-1:0]  dac    [NCH];
    logic [NCH-1:0] pending;
    logic [15:0]    commit_cnt_q;

    analog_pwm_rr_arb u_arb (
        .adc_clk_i (adc_clk_i),
        .adc_rst_i (adc_rst_i),
        .req       ({aux_vld_i, cpu_vld_i}),
        .gnt       (gnt)
    );

    assign cpu_rdy_o = gnt[0];
    assign aux_rdy_o = gnt[1];

    always_comb begin
        req.ch  = gnt[1] ? aux_ch_i  : cpu_ch_i;
        req.dat = gnt[1] ? aux_dat_i : cpu_dat_i;
        // Owner bit 1 selects requester B, so ownership matches when it equals gnt[1].
        owned   = (own_i[req.ch] == gnt[1]);
        wr_en   = (|gnt) && owned;
        commit  = pwm_sync_i && !sync_q;
    end

    always_ff @(posedge adc_clk_i or negedge adc_rst_i) begin
        if (!adc_rst_i) begin
            sync_q       <= 1'b0;
            cpu_err_o    <= 1'b0;
            aux_err_o    <= 1'b0;
            commit_cnt_q <= 16'd0;
            pending      <= '0;
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
                dac[i]    <= '0;
            end
        end else begin
            sync_q    <= pwm_sync_i;
            cpu_err_o <= gnt[0] && !owned;
            aux_err_o <= gnt[1] && !owned;
            if (commit) begin
                commit_cnt_q <= commit_cnt_q + 16'd1;
            end
            // Commit reads pre-edge shadow; a same-edge write re-arms pending for the next sync.
            for (int i = 0; i < NCH; i++) begin
                if (commit && pending[i]) begin
                    dac[i] <= shadow[i];
                end
                if (wr_en && (req.ch == ch_t'(i))) begin
                    shadow[i]  <= pwm_clamp(req.dat);
                    pending[i] <= 1'b1;
                end else if (commit) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    assign dac_pwm_a_o  = dac[0];
    assign dac_pwm_b_o  = dac[1];
    assign dac_pwm_c_o  = dac[2];
    assign dac_pwm_d_o  = dac[3];
    assign pending_o    = pending;
    assign commit_cnt_o = commit_cnt_q;

endmodule

// File: tb/tb_analog_pwm_sched.sv
// Self-checking bench for analog_pwm_sched: reference model plus scoreboard of committed values.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_analog_pwm_sched;

    logic        adc_clk_i  = 1'b0;
    logic        adc_rst_i  = 1'b0;
    logic        cpu_vld_i  = 1'b0;
    logic [1:0]  cpu_ch_i   = 2'd0;
    logic [23:0] cpu_dat_i  = 24'd0;
    logic        aux_vld_i  = 1'b0;
    logic [1:0]  aux_ch_i   = 2'd0;
    logic [23:0] aux_dat_i  = 24'd0;
    logic [3:0]  own_i      = 4'b0000;
    logic        pwm_sync_i = 1'b0;
    logic        cpu_rdy_o, aux_rdy_o, cpu_err_o, aux_err_o;
    logic [23:0] dac_pwm_a_o, dac_pwm_b_o, dac_pwm_c_o, dac_pwm_d_o;
    logic [3:0]  pending_o;
    logic [15:0] commit_cnt_o;

    analog_pwm_sched dut (
        .adc_clk_i    (adc_clk_i),
        .adc_rst_i    (adc_rst_i),
        .cpu_vld_i    (cpu_vld_i),
        .cpu_rdy_o    (cpu_rdy_o),
        .cpu_ch_i     (cpu_ch_i),
        .cpu_dat_i    (cpu_dat_i),
        .aux_vld_i    (aux_vld_i),
        .aux_rdy_o    (aux_rdy_o),
        .aux_ch_i     (aux_ch_i),
        .aux_dat_i    (aux_dat_i),
        .own_i        (own_i),
        .pwm_sync_i   (pwm_sync_i),
        .dac_pwm_a_o  (dac_pwm_a_o),
        .dac_pwm_b_o  (dac_pwm_b_o),
        .dac_pwm_c_o  (dac_pwm_c_o),
        .dac_pwm_d_o  (dac_pwm_d_o),
        .pending_o    (pending_o),
        .cpu_err_o    (cpu_err_o),
        .aux_err_o    (aux_err_o),
        .commit_cnt_o (commit_cnt_o)
    );

    always #5 adc_clk_i = ~adc_clk_i;

    typedef struct packed {
        logic [1:0]  ch;
        logic [23:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [23:0] m_sh  [4];
    logic [23:0] m_dac [4];
    logic [3:0]  m_pend   = 4'b0000;
    logic [15:0] m_cnt    = 16'd0;
    logic        m_prio_b = 1'b0;

    function automatic logic [23:0] clamp_m(input logic [23:0] v);
        if (v[23:16] > 8'd156) return 24'h9C0000;
        return v;
    endfunction

    function automatic logic [23:0] dac_of(input logic [1:0] ch);
        case (ch)
            2'd0:    return dac_pwm_a_o;
            2'd1:    return dac_pwm_b_o;
            2'd2:    return dac_pwm_c_o;
            default: return dac_pwm_d_o;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = 24'd0;
            m_dac[i] = 24'd0;
        end
        m_pend   = 4'b0000;
        m_cnt    = 16'd0;
        m_prio_b = 1'b0;
        sb_q.delete();
    endtask

    task automatic m_write(input logic [1:0] ch, input logic [23:0] d, input logic src_b);
        if (own_i[ch] == src_b) begin
            m_sh[ch]   = clamp_m(d);
            m_pend[ch] = 1'b1;
        end
        m_prio_b = !src_b;
    endtask

    task automatic m_commit();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i]) begin
                m_dac[i] = m_sh[i];
                e.ch     = 2'(i);
                e.val    = m_sh[i];
                sb_q.push_back(e);
            end
        end
        m_pend = 4'b0000;
        m_cnt  = m_cnt + 16'd1;
    endtask

    task automatic cpu_wr(input logic [1:0] ch, input logic [23:0] d);
        int n = 0;
        cpu_vld_i = 1'b1; cpu_ch_i = ch; cpu_dat_i = d;
        #1;
        while (!cpu_rdy_o && n < 20) begin
            @(posedge adc_clk_i); #1; n++;
        end
        if (n == 20) begin
            total++; bad++;
            $display("FAIL cpu_wr_timeout got=rdy_low exp=rdy_high");
        end else begin
            m_write(ch, d, 1'b0);
            @(posedge adc_clk_i); #1;
        end
        cpu_vld_i = 1'b0;
    endtask

    // One idle edge first so the previous pulse has left the sync history.
    task automatic sync_pulse();
        @(posedge adc_clk_i); #1;
        pwm_sync_i = 1'b1;
        m_commit();
        @(posedge adc_clk_i); #1;
        pwm_sync_i = 1'b0;
    endtask

    task automatic test_reset();
        cpu_vld_i = 1'b1; aux_vld_i = 1'b1;
        #3;
        total++; if (cpu_rdy_o !== 1'b0) begin bad++; $display("FAIL rst_cpu_rdy got=%b exp=0", cpu_rdy_o); end
        total++; if (aux_rdy_o !== 1'b0) begin bad++; $display("FAIL rst_aux_rdy got=%b exp=0", aux_rdy_o); end
        cpu_vld_i = 1'b0; aux_vld_i = 1'b0;
        m_reset();
        #19 adc_rst_i = 1'b1;
        @(posedge adc_clk_i); #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dac_of(2'(i)) !== 24'd0) begin bad++; $display("FAIL rst_dac ch%0d got=%h exp=0", i, dac_of(2'(i))); end
        end
        total++; if (pending_o !== 4'b0000) begin bad++; $display("FAIL rst_pending got=%b exp=0000", pending_o); end
        total++; if (commit_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", commit_cnt_o); end
        total++; if ({cpu_err_o, aux_err_o} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", {cpu_err_o, aux_err_o}); end
    endtask

    task automatic test_basic();
        exp_t e;
        own_i = 4'b0000;
        cpu_wr(2'd0, 24'h500000);
        total++; if (pending_o !== 4'b0001) begin bad++; $display("FAIL basic_pending got=%b exp=0001", pending_o); end
        sync_pulse();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); total++;
            if (dac_of(e.ch) !== e.val) begin bad++; $display("FAIL basic_dac ch%0d got=%h exp=%h", e.ch, dac_of(e.ch), e.val); end
        end
        total++; if (dac_pwm_a_o !== 24'h500000) begin bad++; $display("FAIL basic_dac_a got=%h exp=500000", dac_pwm_a_o); end
        total++; if (pending_o !== 4'b0000) begin bad++; $display("FAIL basic_pending_clr got=%b exp=0000", pending_o); end
        total++; if (commit_cnt_o !== 16'd1) begin bad++; $display("FAIL basic_cnt got=%0d exp=1", commit_cnt_o); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int na = 0, nb = 0;
        own_i = 4'b0101;
        cpu_ch_i = 2'd1; aux_ch_i = 2'd0;
        cpu_vld_i = 1'b1; aux_vld_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cpu_dat_i = 24'h010000 + 24'(na);
            aux_dat_i = 24'h020000 + 24'(nb);
            #1;
            total++;
            if (cpu_rdy_o !== !m_prio_b || aux_rdy_o !== m_prio_b) begin
                bad++; $display("FAIL rr_grant cyc%0d got=%b%b exp=%b%b", k, aux_rdy_o, cpu_rdy_o, m_prio_b, !m_prio_b);
            end
            if (m_prio_b) begin m_write(2'd0, aux_dat_i, 1'b1); nb++; end
            else          begin m_write(2'd1, cpu_dat_i, 1'b0); na++; end
            @(posedge adc_clk_i); #1;
        end
        cpu_vld_i = 1'b0; aux_vld_i = 1'b0;
        total++; if (na != 4 || nb != 4) begin bad++; $display("FAIL rr_count got=%0d/%0d exp=4/4", na, nb); end
        repeat (3) @(posedge adc_clk_i);
        #1;
        cpu_vld_i = 1'b1; aux_vld_i = 1'b1;
        #1;
        total++;
        if (cpu_rdy_o !== !m_prio_b || aux_rdy_o !== m_prio_b) begin
            bad++; $display("FAIL rr_idle_hold got=%b%b exp=%b%b", aux_rdy_o, cpu_rdy_o, m_prio_b, !m_prio_b);
        end
        cpu_vld_i = 1'b0; aux_vld_i = 1'b0;
        sync_pulse();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); total++;
            if (dac_of(e.ch) !== e.val) begin bad++; $display("FAIL rr_dac ch%0d got=%h exp=%h", e.ch, dac_of(e.ch), e.val); end
        end
    endtask

    task automatic test_err();
        own_i = 4'b0101;
        aux_vld_i = 1'b1; aux_ch_i = 2'd1; aux_dat_i = 24'h333333;
        #1;
        total++; if (aux_rdy_o !== 1'b1) begin bad++; $display("FAIL err_aux_rdy got=%b exp=1", aux_rdy_o); end
        m_write(2'd1, aux_dat_i, 1'b1);
        @(posedge adc_clk_i); #1;
        aux_vld_i = 1'b0;
        total++; if ({aux_err_o, cpu_err_o} !== 2'b10) begin bad++; $display("FAIL err_aux_pulse got=%b exp=10", {aux_err_o, cpu_err_o}); end
        total++; if (pending_o !== m_pend) begin bad++; $display("FAIL err_pending got=%b exp=%b", pending_o, m_pend); end
        @(posedge adc_clk_i); #1;
        total++; if (aux_err_o !== 1'b0) begin bad++; $display("FAIL err_aux_clear got=%b exp=0", aux_err_o); end
        cpu_wr(2'd0, 24'h444444);
        total++; if ({aux_err_o, cpu_err_o} !== 2'b01) begin bad++; $display("FAIL err_cpu_pulse got=%b exp=01", {aux_err_o, cpu_err_o}); end
        sync_pulse();
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL err_sb_empty got=%0d exp=0", sb_q.size()); end
        total++; if (dac_pwm_b_o !== m_dac[1]) begin bad++; $display("FAIL err_dac_b got=%h exp=%h", dac_pwm_b_o, m_dac[1]); end
        total++; if (dac_pwm_a_o !== m_dac[0]) begin bad++; $display("FAIL err_dac_a got=%h exp=%h", dac_pwm_a_o, m_dac[0]); end
        total++; if (commit_cnt_o !== m_cnt) begin bad++; $display("FAIL err_cnt got=%0d exp=%0d", commit_cnt_o, m_cnt); end
    endtask

    task automatic test_clamp();
        exp_t e;
        logic [23:0] vals [3];
        vals[0] = 24'hFF1234; vals[1] = 24'h9C1234; vals[2] = 24'h9D0000;
        own_i = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            cpu_wr(2'd2, vals[k]);
            sync_pulse();
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front(); total++;
                if (dac_of(e.ch) !== e.val) begin bad++; $display("FAIL clamp_dac in=%h got=%h exp=%h", vals[k], dac_of(e.ch), e.val); end
            end
        end
    endtask

    task automatic test_coincident();
        exp_t e;
        own_i = 4'b0000;
        cpu_wr(2'd3, 24'h000020);
        cpu_vld_i = 1'b1; cpu_ch_i = 2'd3; cpu_dat_i = 24'h000010;
        pwm_sync_i = 1'b1;
        #1;
        total++; if (cpu_rdy_o !== 1'b1) begin bad++; $display("FAIL coin_rdy got=%b exp=1", cpu_rdy_o); end
        m_commit();
        m_write(2'd3, 24'h000010, 1'b0);
        @(posedge adc_clk_i); #1;
        cpu_vld_i = 1'b0; pwm_sync_i = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); total++;
            if (dac_of(e.ch) !== e.val) begin bad++; $display("FAIL coin_dac1 ch%0d got=%h exp=%h", e.ch, dac_of(e.ch), e.val); end
        end
        total++; if (pending_o !== m_pend) begin bad++; $display("FAIL coin_pending got=%b exp=%b", pending_o, m_pend); end
        sync_pulse();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); total++;
            if (dac_of(e.ch) !== e.val) begin bad++; $display("FAIL coin_dac2 ch%0d got=%h exp=%h", e.ch, dac_of(e.ch), e.val); end
        end
    endtask

    task automatic test_sync_held();
        exp_t e;
        own_i = 4'b0000;
        cpu_wr(2'd0, 24'h123456);
        @(posedge adc_clk_i); #1;
        pwm_sync_i = 1'b1;
        m_commit();
        repeat (5) @(posedge adc_clk_i);
        #1;
        pwm_sync_i = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); total++;
            if (dac_of(e.ch) !== e.val) begin bad++; $display("FAIL held_dac ch%0d got=%h exp=%h", e.ch, dac_of(e.ch), e.val); end
        end
        total++; if (commit_cnt_o !== m_cnt) begin bad++; $display("FAIL held_cnt got=%0d exp=%0d", commit_cnt_o, m_cnt); end
    endtask

    task automatic test_wrap();
        force dut.commit_cnt_q = 16'hFFFE;
        #1;
        release dut.commit_cnt_q;
        m_cnt = 16'hFFFE;
        sync_pulse();
        total++; if (commit_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff got=%h exp=ffff", commit_cnt_o); end
        sync_pulse();
        total++; if (commit_cnt_o !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", commit_cnt_o); end
        sb_q.delete();
    endtask

    task automatic test_reset_mid();
        own_i = 4'b0000;
        for (int i = 0; i < 4; i++) cpu_wr(2'(i), 24'h050000 + 24'(i));
        total++; if (pending_o !== 4'b1111) begin bad++; $display("FAIL mid_pending_pre got=%b exp=1111", pending_o); end
        #2;
        adc_rst_i = 1'b0;
        cpu_vld_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dac_of(2'(i)) !== 24'd0) begin bad++; $display("FAIL mid_dac ch%0d got=%h exp=0", i, dac_of(2'(i))); end
        end
        total++; if (pending_o !== 4'b0000) begin bad++; $display("FAIL mid_pending got=%b exp=0000", pending_o); end
        total++; if (commit_cnt_o !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%h exp=0", commit_cnt_o); end
        total++; if (cpu_rdy_o !== 1'b0) begin bad++; $display("FAIL mid_rdy got=%b exp=0", cpu_rdy_o); end
        cpu_vld_i = 1'b0;
        m_reset();
        #2 adc_rst_i = 1'b1;
        repeat (3) @(posedge adc_clk_i);
        #1;
        total++; if (commit_cnt_o !== 16'd0) begin bad++; $display("FAIL mid_nocommit got=%h exp=0", commit_cnt_o); end
        cpu_vld_i = 1'b1; aux_vld_i = 1'b1;
        #1;
        total++; if ({aux_rdy_o, cpu_rdy_o} !== 2'b01) begin bad++; $display("FAIL mid_ptr got=%b exp=01", {aux_rdy_o, cpu_rdy_o}); end
        cpu_vld_i = 1'b0; aux_vld_i = 1'b0;
        sync_pulse();
        total++; if (dac_pwm_a_o !== 24'd0) begin bad++; $display("FAIL mid_dac_after got=%h exp=0", dac_pwm_a_o); end
        total++; if (commit_cnt_o !== m_cnt) begin bad++; $display("FAIL mid_cnt_after got=%0d exp=%0d", commit_cnt_o, m_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_err();
        test_clamp();
        test_coincident();
        test_sync_held();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
